// File: rtl/cpu_thread_pc_pkg.sv
// Shared constants and the next-pc selector for the per-thread PC unit.
package cpu_thread_pc_pkg;

    localparam int DEF_IADDR_LEN = 8;
    localparam int DEF_N_THREADS = 4;

    // Index of the most significant set bit needed to hold v (minimum 0).
    function automatic int msb_of(input int v);
        return (v < 1) ? 0 : $clog2(v + 1) - 1;
    endfunction

    // Source of the next pc value chosen each cycle.
    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_LOAD = 3'd1,
        SEL_INC  = 3'd2,
        SEL_JUMP = 3'd3,
        SEL_CALL = 3'd4,
        SEL_RET  = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/cpu_thread_mem.sv
// Per-thread distributed RAM: one synchronous write port, one asynchronous read port.
module cpu_thread_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Contents are deliberately not reset; the controller initialises each thread.
    logic [DW-1:0] r_mem [DEPTH];

    // Write port, effective at the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_thread_pc.sv
// Per-thread program counter with one-level call/return and thread load/save.
module cpu_thread_pc
    import cpu_thread_pc_pkg::*;
#(
    parameter int N_THREADS     = DEF_N_THREADS,
    parameter int N_THREADS_MSB = msb_of(N_THREADS - 1),
    parameter int ADDR_WIDTH    = DEF_IADDR_LEN
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [N_THREADS_MSB:0] thread_num,
    input  logic                   load_en,
    input  logic                   save_en,
    input  logic                   init_en,
    input  logic [N_THREADS_MSB:0] init_thread,
    input  logic [ADDR_WIDTH-1:0]  init_addr,
    input  logic                   instr_valid,
    input  logic                   op_jump,
    input  logic                   op_call,
    input  logic                   op_return,
    input  logic [ADDR_WIDTH-1:0]  jump_addr,
    input  logic                   condition_is_true,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   jump_taken,
    output logic                   stack_err
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_ret;
    logic [N_THREADS-1:0]  r_ret_valid;
    logic                  r_jump_taken;
    logic                  r_stack_err;

    logic [ADDR_WIDTH-1:0]    w_pc_inc;
    logic [ADDR_WIDTH-1:0]    w_pc_rd;
    logic [ADDR_WIDTH-1:0]    w_ret_rd;
    logic                     w_pc_we;
    logic [N_THREADS_MSB:0]   w_pc_waddr;
    logic [ADDR_WIDTH-1:0]    w_pc_wdata;
    logic                     w_cur_rv;
    pc_sel_e                  w_sel;
    logic                     w_err_set;

    assign w_pc_inc = r_pc + ADDR_WIDTH'(1);
    assign w_cur_rv = r_ret_valid[thread_num];

    // init_en owns the single pc write port; a same-cycle save is dropped.
    assign w_pc_we    = init_en | save_en;
    assign w_pc_waddr = init_en ? init_thread : thread_num;
    assign w_pc_wdata = init_en ? init_addr : r_pc;

    cpu_thread_mem #(
        .DEPTH (N_THREADS),
        .AW    (N_THREADS_MSB + 1),
        .DW    (ADDR_WIDTH)
    ) u_pc_mem (
        .i_clk   (CLK),
        .i_we    (w_pc_we),
        .i_waddr (w_pc_waddr),
        .i_wdata (w_pc_wdata),
        .i_raddr (thread_num),
        .o_rdata (w_pc_rd)
    );

    cpu_thread_mem #(
        .DEPTH (N_THREADS),
        .AW    (N_THREADS_MSB + 1),
        .DW    (ADDR_WIDTH)
    ) u_ret_mem (
        .i_clk   (CLK),
        .i_we    (save_en),
        .i_waddr (thread_num),
        .i_wdata (r_ret),
        .i_raddr (thread_num),
        .o_rdata (w_ret_rd)
    );

    // Next-pc decode: load beats execute; return > call > jump among taken ops.
    always_comb begin
        w_sel     = SEL_HOLD;
        w_err_set = 1'b0;
        if (load_en) begin
            w_sel = SEL_LOAD;
        end else if (instr_valid) begin
            if (op_return && condition_is_true) begin
                if (w_cur_rv) begin
                    w_sel = SEL_RET;
                end else begin
                    w_sel     = SEL_INC;
                    w_err_set = 1'b1;
                end
            end else if (op_call && condition_is_true) begin
                w_sel     = SEL_CALL;
                w_err_set = w_cur_rv;
            end else if (op_jump && condition_is_true) begin
                w_sel = SEL_JUMP;
            end else begin
                w_sel = SEL_INC;
            end
        end
    end

    // Live pc/ret registers and the one-cycle taken pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pc         <= '0;
            r_ret        <= '0;
            r_jump_taken <= 1'b0;
        end else begin
            r_jump_taken <= 1'b0;
            case (w_sel)
                SEL_LOAD: begin
                    r_pc  <= w_pc_rd;
                    r_ret <= w_ret_rd;
                end
                SEL_INC:  r_pc <= w_pc_inc;
                SEL_JUMP: begin
                    r_pc         <= jump_addr;
                    r_jump_taken <= 1'b1;
                end
                SEL_CALL: begin
                    r_pc         <= jump_addr;
                    r_ret        <= w_pc_inc;
                    r_jump_taken <= 1'b1;
                end
                SEL_RET: begin
                    r_pc         <= r_ret;
                    r_jump_taken <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Per-thread return-valid bits; init clears last so it overrides a call.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ret_valid <= '0;
        end else begin
            if (w_sel == SEL_CALL)     r_ret_valid[thread_num] <= 1'b1;
            else if (w_sel == SEL_RET) r_ret_valid[thread_num] <= 1'b0;
            if (init_en)               r_ret_valid[init_thread] <= 1'b0;
        end
    end

    // Sticky misuse flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)       r_stack_err <= 1'b0;
        else if (w_err_set) r_stack_err <= 1'b1;
    end

    assign pc         = r_pc;
    assign jump_taken = r_jump_taken;
    assign stack_err  = r_stack_err;

endmodule

// File: tb/tb_cpu_thread_pc.sv
// Directed bench for cpu_thread_pc with a per-cycle reference model.
module tb_cpu_thread_pc;

    localparam int NT = 4;
    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic [1:0]    thread_num = '0;
    logic          load_en = 1'b0, save_en = 1'b0, init_en = 1'b0;
    logic [1:0]    init_thread = '0;
    logic [AW-1:0] init_addr = '0;
    logic          instr_valid = 1'b0, op_jump = 1'b0, op_call = 1'b0, op_return = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic          condition_is_true = 1'b0;
    logic [AW-1:0] pc;
    logic          jump_taken, stack_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    cpu_thread_pc #(.N_THREADS(NT), .N_THREADS_MSB(1), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .thread_num(thread_num),
        .load_en(load_en), .save_en(save_en), .init_en(init_en),
        .init_thread(init_thread), .init_addr(init_addr),
        .instr_valid(instr_valid), .op_jump(op_jump), .op_call(op_call),
        .op_return(op_return), .jump_addr(jump_addr),
        .condition_is_true(condition_is_true),
        .pc(pc), .jump_taken(jump_taken), .stack_err(stack_err)
    );

    always #5 CLK = ~CLK;

    // Reference model: architectural state as plain integers.
    int m_pc = 0, m_ret = 0;
    int m_pcmem[NT] = '{default: 0};
    int m_retmem[NT] = '{default: 0};
    bit m_rv[NT] = '{default: 1'b0};
    bit m_jt = 1'b0, m_err = 1'b0;

    always @(posedge CLK or negedge RESET_N) begin
        int old_pc, old_ret, t;
        bit taken;
        if (!RESET_N) begin
            m_pc = 0; m_ret = 0; m_jt = 0; m_err = 0;
            for (int i = 0; i < NT; i++) m_rv[i] = 0;
        end else begin
            old_pc  = m_pc;
            old_ret = m_ret;
            t       = int'(thread_num);
            taken   = (op_jump | op_call | op_return) & condition_is_true;
            m_jt    = 0;
            if (load_en) begin
                m_pc  = m_pcmem[t];
                m_ret = m_retmem[t];
            end else if (instr_valid) begin
                if (taken && op_return) begin
                    if (m_rv[t]) begin
                        m_pc = old_ret; m_rv[t] = 0; m_jt = 1;
                    end else begin
                        m_err = 1; m_pc = (old_pc + 1) % (1 << AW);
                    end
                end else if (taken && op_call) begin
                    if (m_rv[t]) m_err = 1;
                    m_ret = (old_pc + 1) % (1 << AW);
                    m_pc = int'(jump_addr); m_rv[t] = 1; m_jt = 1;
                end else if (taken) begin
                    m_pc = int'(jump_addr); m_jt = 1;
                end else begin
                    m_pc = (old_pc + 1) % (1 << AW);
                end
            end
            if (save_en) begin
                m_pcmem[t] = old_pc;
                m_retmem[t] = old_ret;
            end
            if (init_en) begin
                m_pcmem[int'(init_thread)] = int'(init_addr);
                m_rv[int'(init_thread)] = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_pc", int'(pc), m_pc);
            check("model_jump_taken", int'(jump_taken), int'(m_jt));
            check("model_stack_err", int'(stack_err), int'(m_err));
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic clr();
        load_en = 0; save_en = 0; init_en = 0; instr_valid = 0;
        op_jump = 0; op_call = 0; op_return = 0; condition_is_true = 0;
    endtask

    task automatic do_init(input int t, input int a);
        init_en = 1; init_thread = 2'(t); init_addr = AW'(a); tick(); clr();
    endtask

    task automatic do_load(input int t);
        thread_num = 2'(t); load_en = 1; tick(); clr();
    endtask

    task automatic do_save(input int t);
        thread_num = 2'(t); save_en = 1; tick(); clr();
    endtask

    // j/c/r op bits, condition, target
    task automatic do_instr(input bit j, input bit c, input bit r, input bit cond, input int ja);
        instr_valid = 1; op_jump = j; op_call = c; op_return = r;
        condition_is_true = cond; jump_addr = AW'(ja); tick(); clr();
    endtask

    initial begin
        #1 RESET_N = 0;
        chk_en = 1;
        repeat (2) tick();
        check("reset_pc", int'(pc), 0);
        check("reset_jt", int'(jump_taken), 0);
        check("reset_err", int'(stack_err), 0);
        RESET_N = 1;
        tick();

        // Reset and init
        do_init(0, 'h30); do_init(1, 'h50); do_init(2, 'h40); do_init(3, 'hFE);
        do_load(2);
        check("init_load_pc", int'(pc), 'h40);
        check("init_load_err", int'(stack_err), 0);

        // Sequential and wrap
        do_load(3);
        do_instr(0, 0, 0, 0, 0);
        check("seq_pc", int'(pc), 'hFF);
        do_instr(0, 0, 0, 0, 0);
        check("wrap_pc", int'(pc), 'h00);
        check("wrap_jt", int'(jump_taken), 0);

        // Conditional jump
        do_instr(1, 0, 0, 0, 'h10);
        check("jmp_nottaken_pc", int'(pc), 'h01);
        do_instr(1, 0, 0, 1, 'h10);
        check("jmp_taken_pc", int'(pc), 'h10);
        check("jmp_taken_jt", int'(jump_taken), 1);
        tick();
        check("jt_pulse_clears", int'(jump_taken), 0);

        // Call / return
        do_instr(1, 0, 0, 1, 'h05);
        do_instr(0, 1, 0, 1, 'h20);
        check("call_pc", int'(pc), 'h20);
        do_instr(0, 0, 1, 1, 0);
        check("ret_pc", int'(pc), 'h06);
        check("ret_jt", int'(jump_taken), 1);
        do_instr(0, 0, 1, 1, 0);
        check("ret2_pc", int'(pc), 'h07);
        check("ret2_err", int'(stack_err), 1);
        check("ret2_jt", int'(jump_taken), 0);

        // Thread switch
        do_save(3);
        do_load(0);
        repeat (3) do_instr(0, 0, 0, 0, 0);
        check("t0_run_pc", int'(pc), 'h33);
        do_save(0);
        do_load(1);
        repeat (3) do_instr(0, 0, 0, 0, 0);
        check("t1_run_pc", int'(pc), 'h53);
        do_save(1);
        do_load(0);
        check("t0_restore_pc", int'(pc), 'h33);
        do_load(1);
        check("t1_restore_pc", int'(pc), 'h53);

        // init + save same thread: init wins
        thread_num = 0; save_en = 1; init_en = 1; init_thread = 0; init_addr = 'h77;
        tick(); clr();
        do_load(0);
        check("init_save_collide", int'(pc), 'h77);

        // load + instr_valid: load wins, no pulse
        thread_num = 3; load_en = 1; instr_valid = 1; op_jump = 1;
        condition_is_true = 1; jump_addr = 'h99;
        tick(); clr();
        check("load_instr_pc", int'(pc), 'h07);
        check("load_instr_jt", int'(jump_taken), 0);

        // save + instr_valid: register advances, memory keeps old pc
        thread_num = 3; save_en = 1; instr_valid = 1;
        tick(); clr();
        check("save_instr_live", int'(pc), 'h08);
        do_load(3);
        check("save_instr_mem", int'(pc), 'h07);

        // init of running thread overrides same-cycle call
        thread_num = 3; instr_valid = 1; op_call = 1; condition_is_true = 1;
        jump_addr = 'h20; init_en = 1; init_thread = 3; init_addr = 'h90;
        tick(); clr();
        check("init_call_pc", int'(pc), 'h20);
        do_instr(0, 0, 1, 1, 0);
        check("init_clears_rv_pc", int'(pc), 'h21);
        check("init_clears_rv_jt", int'(jump_taken), 0);

        // Asynchronous reset mid-cycle
        #2 RESET_N = 0;
        #1;
        check("async_rst_pc", int'(pc), 0);
        check("async_rst_err", int'(stack_err), 0);
        tick();
        RESET_N = 1;
        tick();

        // Double call flags error; return goes to latest ret
        do_load(2);
        check("post_rst_load", int'(pc), 'h40);
        do_instr(0, 1, 0, 1, 'h10);
        do_instr(0, 1, 0, 1, 'h20);
        check("dbl_call_err", int'(stack_err), 1);
        do_instr(0, 0, 1, 1, 0);
        check("dbl_call_ret_pc", int'(pc), 'h11);

        // All op bits: return has priority, rv=0 so it falls through
        do_instr(1, 1, 1, 1, 'h55);
        check("multi_op_pc", int'(pc), 'h12);
        check("multi_op_jt", int'(jump_taken), 0);

        tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
